// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit CPU datapath: control-word bit positions,
// the idle control word, the loader's control words and its FSM state type.
package cpu_pkg;

  localparam int unsigned CTRL_W = 15;

  // Control-word bit positions, [14]Cp down to [0]nLo
  localparam int unsigned CP_BIT   = 14;
  localparam int unsigned EP_BIT   = 13;
  localparam int unsigned LP_BIT   = 12;
  localparam int unsigned NLMA_BIT = 11;
  localparam int unsigned NLMD_BIT = 10;
  localparam int unsigned NCE_BIT  = 9;
  localparam int unsigned NLR_BIT  = 8;
  localparam int unsigned NLI_BIT  = 7;
  localparam int unsigned EI_BIT   = 6;
  localparam int unsigned NLA_BIT  = 5;
  localparam int unsigned EA_BIT   = 4;
  localparam int unsigned SU_BIT   = 3;
  localparam int unsigned EU_BIT   = 2;
  localparam int unsigned NLB_BIT  = 1;
  localparam int unsigned NLO_BIT  = 0;

  // All active-high enables 0, all active-low loads 1: nothing drives or loads
  localparam logic [CTRL_W-1:0] CTRL_IDLE = 15'h0FA3;

  // Loader words: idle with exactly one active-low RAM-path strobe asserted
  localparam logic [CTRL_W-1:0] CTRL_LD_ADDR  = CTRL_IDLE & ~(15'd1 << NLMA_BIT);
  localparam logic [CTRL_W-1:0] CTRL_LD_DATA  = CTRL_IDLE & ~(15'd1 << NLMD_BIT);
  localparam logic [CTRL_W-1:0] CTRL_LD_WRITE = CTRL_IDLE & ~(15'd1 << NLR_BIT);

  typedef enum logic [2:0] {
    RUN,
    HOLD,
    ADDR,
    DATA,
    WRITE,
    ADVANCE,
    EXIT
  } loader_state_t;

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchronizer for an asynchronous pad input. With RISE_EDGE=1 the
// output is a one-cycle pulse on each synchronized rising edge; with
// RISE_EDGE=0 it is the synchronized level. SYNC_STAGES must be at least 2.
module sync_edge_detect #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter bit          RISE_EDGE   = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic async_i,
  output logic sync_o
);

  logic [SYNC_STAGES-1:0] r_sync;

  // Shift the async input through the synchronizer chain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], async_i};
    end
  end

  if (RISE_EDGE) begin : g_rise
    logic r_prev;

    // Remember the last synchronized level for edge detection
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_prev <= 1'b0;
      end else begin
        r_prev <= r_sync[SYNC_STAGES-1];
      end
    end

    assign sync_o = r_sync[SYNC_STAGES-1] & ~r_prev;
  end else begin : g_level
    assign sync_o = r_sync[SYNC_STAGES-1];
  end

endmodule

// File: rtl/program_loader.sv
// Program loader: lets an external host write a program into RAM byte by
// byte while the CPU is held off the bus, then restarts the CPU.
// Build option: define LOADER_CHECKSUM_EN to get a running byte checksum on
// checksum_o; otherwise checksum_o is tied to zero.
module program_loader
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W      = 4,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_mode_i,
  input  logic              strobe_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [14:0]       cpu_ctrl_i,
  output logic [14:0]       cpu_ctrl_o,
  output logic [DATA_W-1:0] bus_o,
  output logic              bus_oe_o,
  output logic              cpu_restart_o,
  output logic              busy_o,
  output logic [ADDR_W:0]   count_o,
  output logic              overrun_o,
  output logic [DATA_W-1:0] checksum_o
);

  // Count saturates at the RAM size
  localparam logic [ADDR_W:0] COUNT_MAX = {1'b1, {ADDR_W{1'b0}}};

  loader_state_t     r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W:0]   r_count;
  logic              r_overrun;
  logic              r_pending;
  logic [DATA_W-1:0] r_data;
  logic [DATA_W-1:0] r_shadow;
  logic [DATA_W-1:0] r_bus;
  logic              r_bus_oe;
  logic              r_restart;
  logic [14:0]       r_ctrl;

  logic              w_strb_rise;
  logic              w_load_mode;
  logic              w_in_seq;
  logic [DATA_W-1:0] w_addr_ext;

  sync_edge_detect #(
    .SYNC_STAGES(SYNC_STAGES),
    .RISE_EDGE  (1'b1)
  ) u_strobe_sync (
    .clk    (clk),
    .rst    (rst),
    .async_i(strobe_i),
    .sync_o (w_strb_rise)
  );

  sync_edge_detect #(
    .SYNC_STAGES(SYNC_STAGES),
    .RISE_EDGE  (1'b0)
  ) u_load_mode_sync (
    .clk    (clk),
    .rst    (rst),
    .async_i(load_mode_i),
    .sync_o (w_load_mode)
  );

  assign w_in_seq   = r_state inside {ADDR, DATA, WRITE, ADVANCE};
  assign w_addr_ext = {{(DATA_W - ADDR_W){1'b0}}, r_addr};

  // Loader FSM with registered bus/control outputs set on entry to each state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= RUN;
      r_addr    <= '0;
      r_count   <= '0;
      r_overrun <= 1'b0;
      r_pending <= 1'b0;
      r_data    <= '0;
      r_shadow  <= '0;
      r_bus     <= '0;
      r_bus_oe  <= 1'b0;
      r_restart <= 1'b0;
      r_ctrl    <= CTRL_IDLE;
    end else begin
      r_bus     <= '0;
      r_bus_oe  <= 1'b0;
      r_restart <= 1'b0;
      r_ctrl    <= CTRL_IDLE;

      // A strobe arriving mid-write is parked in the shadow register; a
      // second one before it is consumed is lost
      if (w_strb_rise && w_in_seq) begin
        if (r_pending) begin
          r_overrun <= 1'b1;
        end else begin
          r_pending <= 1'b1;
          r_shadow  <= data_i;
        end
      end

      case (r_state)
        RUN: begin
          if (w_load_mode) begin
            r_state   <= HOLD;
            r_addr    <= '0;
            r_count   <= '0;
            r_overrun <= 1'b0;
            r_pending <= 1'b0;
          end
        end
        HOLD: begin
          if (w_strb_rise || r_pending) begin
            if (r_pending) begin
              r_data    <= r_shadow;
              r_pending <= 1'b0;
              if (w_strb_rise) begin
                r_overrun <= 1'b1;
              end
            end else begin
              r_data <= data_i;
            end
            r_state  <= ADDR;
            r_bus    <= w_addr_ext;
            r_bus_oe <= 1'b1;
            r_ctrl   <= CTRL_LD_ADDR;
          end else if (!w_load_mode) begin
            r_state   <= EXIT;
            r_restart <= 1'b1;
          end
        end
        ADDR: begin
          r_state  <= DATA;
          r_bus    <= r_data;
          r_bus_oe <= 1'b1;
          r_ctrl   <= CTRL_LD_DATA;
        end
        DATA: begin
          r_state  <= WRITE;
          r_bus    <= r_data;
          r_bus_oe <= 1'b1;
          r_ctrl   <= CTRL_LD_WRITE;
        end
        WRITE: begin
          r_state <= ADVANCE;
        end
        ADVANCE: begin
          r_addr <= r_addr + 1'b1;
          if (r_count != COUNT_MAX) begin
            r_count <= r_count + 1'b1;
          end
          r_state <= HOLD;
        end
        EXIT: begin
          r_state <= RUN;
        end
        default: begin
          r_state <= RUN;
        end
      endcase
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] r_checksum;

  // Sum each byte as it is written; restart the sum on load-mode entry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_checksum <= '0;
    end else if (r_state == RUN && w_load_mode) begin
      r_checksum <= '0;
    end else if (r_state == WRITE) begin
      r_checksum <= r_checksum + r_data;
    end
  end

  assign checksum_o = r_checksum;
`else
  assign checksum_o = '0;
`endif

  // Pass-through only in RUN; reset forces the idle word asynchronously
  assign cpu_ctrl_o    = rst ? CTRL_IDLE : ((r_state != RUN) ? r_ctrl : cpu_ctrl_i);
  assign bus_o         = r_bus;
  assign bus_oe_o      = r_bus_oe;
  assign cpu_restart_o = r_restart;
  assign busy_o        = (r_state != RUN);
  assign count_o       = r_count;
  assign overrun_o     = r_overrun;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: reset, byte loads with phase timing,
// pending/overrun handling, mid-sequence exit, address wrap and RUN isolation.
module tb_program_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_mode_i;
  logic        strobe_i;
  logic [7:0]  data_i;
  logic [14:0] cpu_ctrl_i;
  logic [14:0] cpu_ctrl_o;
  logic [7:0]  bus_o;
  logic        bus_oe_o;
  logic        cpu_restart_o;
  logic        busy_o;
  logic [4:0]  count_o;
  logic        overrun_o;
  logic [7:0]  checksum_o;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  // Bus-side RAM model and protocol watchdog
  logic [7:0] m_ram [16];
  logic [3:0] m_mar;
  logic [7:0] m_mdr;
  logic       m_ma, m_md, m_wr;
  logic       m_prev_ma = 1'b0;
  logic       m_prev_md = 1'b0;
  int         m_viol = 0;
  int         m_restart_cycles = 0;

  program_loader #(
    .ADDR_W     (4),
    .DATA_W     (8),
    .SYNC_STAGES(2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .load_mode_i  (load_mode_i),
    .strobe_i     (strobe_i),
    .data_i       (data_i),
    .cpu_ctrl_i   (cpu_ctrl_i),
    .cpu_ctrl_o   (cpu_ctrl_o),
    .bus_o        (bus_o),
    .bus_oe_o     (bus_oe_o),
    .cpu_restart_o(cpu_restart_o),
    .busy_o       (busy_o),
    .count_o      (count_o),
    .overrun_o    (overrun_o),
    .checksum_o   (checksum_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      m_ma = busy_o && !cpu_ctrl_o[11];
      m_md = busy_o && !cpu_ctrl_o[10];
      m_wr = busy_o && !cpu_ctrl_o[8];
      if (bus_oe_o !== (m_ma | m_md | m_wr)) m_viol++;
      if ((m_ma && m_md) || (m_ma && m_wr) || (m_md && m_wr)) m_viol++;
      if (m_md && !m_prev_ma) m_viol++;
      if (m_wr && !m_prev_md) m_viol++;
      if (m_ma) m_mar = bus_o[3:0];
      if (m_md) m_mdr = bus_o;
      if (m_wr) begin
        if (bus_o !== m_mdr) m_viol++;
        m_ram[m_mar] = m_mdr;
      end
      if (cpu_restart_o) m_restart_cycles++;
      m_prev_ma = m_ma;
      m_prev_md = m_md;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge; any strobe pulse lasts one cycle
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      strobe_i = 1'b0;
    end
  endtask

  logic [7:0] bytes3 [3] = '{8'h1E, 8'h2F, 8'hE0};
  int bad;

  initial begin
    rst         = 1'b1;
    load_mode_i = 1'b0;
    strobe_i    = 1'b0;
    data_i      = 8'h00;
    cpu_ctrl_i  = 15'h5A5A;
    tick(3);

    // Reset state
    check("rst_ctrl", cpu_ctrl_o, 15'h0FA3);
    check("rst_bus_oe", bus_oe_o, 1'b0);
    check("rst_bus", bus_o, 8'h00);
    check("rst_count", count_o, 5'd0);
    check("rst_busy", busy_o, 1'b0);
    check("rst_restart", cpu_restart_o, 1'b0);
    check("rst_overrun", overrun_o, 1'b0);
    check("rst_checksum", checksum_o, 8'h00);

    rst = 1'b0;
    tick();
    check("passthru_5a5a", cpu_ctrl_o, 15'h5A5A);
    cpu_ctrl_i = 15'h1234;
    tick();
    check("passthru_1234", cpu_ctrl_o, 15'h1234);

    // Reset asserted mid-RUN forces the idle word immediately
    #1 rst = 1'b1;
    #1 check("rst_mid_run_ctrl", cpu_ctrl_o, 15'h0FA3);
    tick();
    rst        = 1'b0;
    cpu_ctrl_i = 15'h5A5A;
    tick();
    check("passthru_after_rst", cpu_ctrl_o, 15'h5A5A);

    // Strobes in RUN are ignored
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      if (i == 0 || i == 5) begin
        data_i   = 8'h77;
        strobe_i = 1'b1;
      end
      cpu_ctrl_i = 15'h5A5A ^ 15'(i * 37);
      #1;
      if (cpu_ctrl_o !== cpu_ctrl_i || bus_oe_o !== 1'b0 || busy_o !== 1'b0) bad++;
      tick();
    end
    cpu_ctrl_i = 15'h5A5A;
    check("run_strobe_isolation", bad, 0);
    check("run_strobe_count", count_o, 5'd0);

    // Enter load mode
    load_mode_i = 1'b1;
    tick(4);
    check("load_busy", busy_o, 1'b1);
    check("load_ctrl_idle", cpu_ctrl_o, 15'h0FA3);

    // Three bytes, strobes 10 cycles apart, with per-phase timing
    for (int i = 0; i < 3; i++) begin
      data_i   = bytes3[i];
      strobe_i = 1'b1;
      tick(2);
      check("hold_before_addr", {bus_oe_o, cpu_ctrl_o}, {1'b1 ^ 1'b1, 15'h0FA3});
      tick();
      check("addr_phase", {bus_oe_o, cpu_ctrl_o, bus_o}, {1'b1, 15'h07A3, 8'(i)});
      tick();
      check("data_phase", {bus_oe_o, cpu_ctrl_o, bus_o}, {1'b1, 15'h0BA3, bytes3[i]});
      tick();
      check("write_phase", {bus_oe_o, cpu_ctrl_o, bus_o}, {1'b1, 15'h0EA3, bytes3[i]});
      tick();
      check("advance_phase", {bus_oe_o, cpu_ctrl_o}, {1'b0, 15'h0FA3});
      tick(4);
    end
    check("three_count", count_o, 5'd3);
    check("three_ram", {m_ram[0], m_ram[1], m_ram[2]}, 24'h1E2FE0);
`ifdef LOADER_CHECKSUM_EN
    check("three_checksum", checksum_o, 8'h2D);
`else
    check("three_checksum", checksum_o, 8'h00);
`endif

    // Drop load_mode during DATA: byte completes, then EXIT and restart
    data_i   = 8'h5C;
    strobe_i = 1'b1;
    tick(4);
    check("drop_data_phase", {bus_oe_o, cpu_ctrl_o, bus_o}, {1'b1, 15'h0BA3, 8'h5C});
    load_mode_i = 1'b0;
    tick();
    check("drop_write_phase", {bus_oe_o, cpu_ctrl_o, bus_o}, {1'b1, 15'h0EA3, 8'h5C});
    tick(2);
    check("drop_hold", {busy_o, cpu_restart_o, cpu_ctrl_o}, {1'b1, 1'b0, 15'h0FA3});
    tick();
    check("drop_exit", {busy_o, cpu_restart_o, cpu_ctrl_o}, {1'b1, 1'b1, 15'h0FA3});
    tick();
    check("drop_run", {busy_o, cpu_restart_o, cpu_ctrl_o}, {1'b0, 1'b0, 15'h5A5A});
    check("drop_count", count_o, 5'd4);
    check("drop_ram", m_ram[3], 8'h5C);

    // Second strobe during the first write: pending path, no overrun
    load_mode_i = 1'b1;
    tick(4);
    check("reentry_count_clear", count_o, 5'd0);
`ifdef LOADER_CHECKSUM_EN
    check("reentry_checksum_clear", checksum_o, 8'h00);
`endif
    data_i   = 8'hA1;
    strobe_i = 1'b1;
    tick(3);
    data_i   = 8'hB2;
    strobe_i = 1'b1;
    tick(5);
    check("pend_addr_phase", {bus_oe_o, cpu_ctrl_o, bus_o}, {1'b1, 15'h07A3, 8'h01});
    tick();
    check("pend_data_phase", {bus_oe_o, cpu_ctrl_o, bus_o}, {1'b1, 15'h0BA3, 8'hB2});
    tick(5);
    check("pend_count", count_o, 5'd2);
    check("pend_overrun", overrun_o, 1'b0);
    check("pend_ram", {m_ram[0], m_ram[1]}, 16'hA1B2);

    // Third strobe while a byte is pending is dropped
    load_mode_i = 1'b0;
    tick(5);
    load_mode_i = 1'b1;
    tick(4);
    data_i   = 8'hC3;
    strobe_i = 1'b1;
    tick(3);
    data_i   = 8'hD4;
    strobe_i = 1'b1;
    tick(2);
    strobe_i = 1'b1;
    tick(9);
    check("ovr_overrun", overrun_o, 1'b1);
    check("ovr_count", count_o, 5'd2);
    check("ovr_ram", {m_ram[0], m_ram[1], m_ram[2]}, 24'hC3D4E0);

    // Overrun clears on re-entry; 17 bytes wrap the address
    load_mode_i = 1'b0;
    tick(5);
    load_mode_i = 1'b1;
    tick(4);
    check("wrap_overrun_clear", overrun_o, 1'b0);
    for (int v = 0; v < 17; v++) begin
      data_i   = 8'(v);
      strobe_i = 1'b1;
      tick(8);
    end
    check("wrap_count_sat", count_o, 5'd16);
    check("wrap_ram", {m_ram[0], m_ram[1], m_ram[15]}, 24'h10010F);
`ifdef LOADER_CHECKSUM_EN
    check("wrap_checksum", checksum_o, 8'h88);
`else
    check("wrap_checksum", checksum_o, 8'h00);
`endif

    load_mode_i = 1'b0;
    tick(5);
    check("final_busy", busy_o, 1'b0);
    check("bus_protocol", m_viol, 0);
    check("restart_pulses", m_restart_cycles, 4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
